// File: rtl/t02_wb_manager.sv
// Wishbone classic single-beat manager for the t02 RAM request port.
// Each Ren/Wen request becomes one CYC/STB cycle with ACK timeout and error reporting.
module t02_wb_manager #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        bus_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        CYC_O,
  output logic        STB_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic        req;
  logic        abort;
  logic        finish;

  assign req    = Ren | Wen;
  // ERR_I wins over a simultaneous ACK_I; an ACK on the final allowed cycle still succeeds
  assign abort  = ERR_I | (~ACK_I & (count == LAST));
  assign finish = ACK_I | abort;
  assign busy_o = ((state == IDLE) & req) | (state == BUS);
  assign SEL_O  = 4'hF;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUS;
      BUS:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CYC_O   <= 1'b0;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      bus_err <= 1'b0;
      ADR_O   <= '0;
      DAT_O   <= '0;
      ramload <= '0;
      count   <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ADR_O <= ramaddr;
            DAT_O <= ramstore;
            WE_O  <= Wen;
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
            count <= '0;
          end
        end
        BUS: begin
          if (abort) begin
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            bus_err <= 1'b1;
            if (!WE_O) ramload <= ERR_DATA;
          end else if (ACK_I) begin
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            if (!WE_O) ramload <= DAT_I;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
